sdmem_arbiter: RTL
==================

Name: sdmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory between the scalar LSU (s_*) and the vector LSU (v_*).
- Round-robin arbitration with vector burst locking, a starvation breaker, and alignment/bounds screening.
- Registered one-cycle read/write response.
- Sits between both load/store units and sdatamem; drives sdatamem's read/write/size/addr/wdata and consumes its combinational rdata.

Parameters:
- DATA_WIDTH, 32, data/address width
- MEM_SIZE, 1024, memory size in bytes; must match sdatamem
- MAX_BURST, 8, consecutive locked vector beats before one scalar slot is forced (range 1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_req_i  in  1  scalar request; held until s_gnt_o
- s_we_i  in  1  scalar write (1) / read (0)
- s_size_i  in  2  00 byte, 01 half, 10/11 word
- s_addr_i  in  DATA_WIDTH  scalar byte address
- s_wdata_i  in  DATA_WIDTH  scalar write data
- s_gnt_o  out  1  scalar grant, combinational, same cycle as the access
- s_rvalid_o  out  1  scalar response pulse
- s_rdata_o  out  DATA_WIDTH  scalar read data
- s_err_o  out  1  scalar error flag, qualified by s_rvalid_o
- v_req_i, v_we_i, v_size_i, v_addr_i, v_wdata_i  in  1/1/2/DATA_WIDTH/DATA_WIDTH  vector request, same semantics as scalar
- v_last_i  in  1  final beat of a vector burst
- v_gnt_o, v_rvalid_o, v_rdata_o, v_err_o  out  1/1/DATA_WIDTH/1  vector response, same semantics as scalar
- mem_read_o  out  1  to sdatamem read enable
- mem_write_o  out  1  to sdatamem write enable
- mem_size_o  out  2  to sdatamem access size
- mem_addr_o  out  DATA_WIDTH  to sdatamem address
- mem_wdata_o  out  DATA_WIDTH  to sdatamem write data
- mem_rdata_i  in  DATA_WIDTH  from sdatamem, combinational read data
- perf_s_gnt_o, perf_v_gnt_o, perf_s_stall_o  out  32 each  performance counters

Behaviour:
- Reset:
  - State IDLE, round-robin pointer favours scalar, beat_cnt=0.
  - All rvalid/err/rdata outputs 0; perf counters 0.
  - mem_* outputs follow the combinational grant, so they are 0 while no grant.
- Grant and memory drive:
  - At most one grant per cycle.
  - mem_* driven combinationally from the granted requester.
  - mem_read_o = gnt & ~we & ok; mem_write_o = gnt & we & ok.
  - All mem_* are 0 when nothing is granted.
- ok check (request is valid when both hold):
  - Aligned: half needs addr[0]=0; word needs addr[1:0]=0.
  - In bounds: addr < MEM_SIZE-3.
  - A failing request is still granted, but no memory strobe is issued.
- Response, exactly one cycle after grant:
  - rvalid pulses for reads and writes on the granted side.
  - rdata = registered mem_rdata_i for an ok read; otherwise 0.
  - err = ~ok.
  - rdata holds its value between pulses.
- State IDLE:
  - Single request → grant it.
  - Both requesting → grant the side opposite the pointer's last grant.
  - Pointer updates on every grant.
  - Vector granted with v_last_i=0 → go to LOCK_V, beat_cnt=1.
- State LOCK_V:
  - Scalar blocked while v_req_i=1.
  - Each vector grant increments beat_cnt.
  - Vector grant with v_last_i=1 → go to IDLE, beat_cnt=0.
  - beat_cnt==MAX_BURST and s_req_i=1 → grant scalar that cycle instead of vector; beat_cnt=0; remain in LOCK_V.
  - v_req_i=0 and s_req_i=1 → scalar uses the idle slot; lock retained, beat_cnt unchanged.
- Boundary cases:
  - Error beats count as beats.
  - A vector err beat with v_last_i=1 still releases the lock.
  - A request that drops before grant is simply not served.
- Reset mid-burst → IDLE; any pending rvalid is dropped (no pulse after reset release).

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - perf_s_gnt_o / perf_v_gnt_o count grants per side.
  - perf_s_stall_o counts cycles with s_req_i=1 & s_gnt_o=0.
  - All counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the three ports are tied to 0 and no counter flops are built.

Decomposition:
- Package sdmem_arb_pkg:
  - mem_size_e (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10)
  - arb_state_e (IDLE, LOCK_V)
  - owner_e (OWN_NONE, OWN_S, OWN_V)
  - function for the alignment check
- Sub-module sdmem_req_check: combinational alignment/bounds check, one instance per requester, parameterised by MEM_SIZE.

Test Plan:
- Scalar-only: s_req_i=1, read word at addr 0x10 with memory 0x11223344 → s_gnt_o same cycle, mem_read_o=1, next cycle s_rvalid_o=1, s_rdata_o=0x11223344, s_err_o=0.
- Contention: both sides request reads for 4 cycles, v_last_i=1 each beat, after reset → grants alternate S,V,S,V.
- Burst lock: vector 4-beat write burst to 0x100..0x10C with v_last_i on beat 4, scalar requesting throughout → scalar granted only in cycle 5; memory holds all 4 words.
- Starvation: MAX_BURST=8, 20-beat vector burst, scalar requesting → scalar granted after vector beats 8 and 16; burst completes; lock released after beat 20.
- Errors: half read at 0x101 → s_err_o=1, mem_read_o=0. Word write at 0x3FE (MEM_SIZE=1024) → v_err_o=1, mem_write_o=0, memory unchanged.
- Reset: assert rst_n low during beat 3 of a locked burst → all outputs 0, no rvalid after release; next scalar request granted immediately.

Source files
------------

// File: rtl/sdmem_arb_pkg.sv
// Shared types and helpers for the scalar/vector data-memory arbiter.
package sdmem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCK_V = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_S    = 2'b01,
    OWN_V    = 2'b10
  } owner_e;

  // Byte accesses are always aligned; size 2'b11 is treated as a word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic aligned;
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~addr_lo[0];
      default: aligned = (addr_lo == 2'b00);
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/sdmem_req_check.sv
// Combinational alignment and bounds screen for one requester.
module sdmem_req_check
  import sdmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic [1:0]            size_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  output logic                  ok_o
);

  // The bound is conservative: every access must leave room for a full word.
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEM_SIZE - 3);

  assign ok_o = is_aligned(size_i, addr_i[1:0]) && (addr_i < ADDR_LIMIT);

endmodule

// File: rtl/sdmem_arbiter.sv
// Scalar/vector arbiter in front of sdatamem: round-robin with vector burst
// locking, a starvation breaker and a registered one-cycle response.
// Optional grant/stall performance counters are built when ARB_PERF_CNT_EN is defined.
module sdmem_arbiter
  import sdmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_req_i,
  input  logic                  s_we_i,
  input  logic [1:0]            s_size_i,
  input  logic [DATA_WIDTH-1:0] s_addr_i,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  output logic                  s_gnt_o,
  output logic                  s_rvalid_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic                  s_err_o,
  input  logic                  v_req_i,
  input  logic                  v_we_i,
  input  logic [1:0]            v_size_i,
  input  logic [DATA_WIDTH-1:0] v_addr_i,
  input  logic [DATA_WIDTH-1:0] v_wdata_i,
  input  logic                  v_last_i,
  output logic                  v_gnt_o,
  output logic                  v_rvalid_o,
  output logic [DATA_WIDTH-1:0] v_rdata_o,
  output logic                  v_err_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [1:0]            mem_size_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           perf_s_gnt_o,
  output logic [31:0]           perf_v_gnt_o,
  output logic [31:0]           perf_s_stall_o
);

  localparam logic [7:0] MAX_BEATS = 8'(MAX_BURST);

  arb_state_e            state_q, state_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  last_v_q, last_v_d;
  owner_e                owner;
  logic                  s_ok, v_ok;
  logic                  s_rvalid_q, s_rvalid_d, v_rvalid_q, v_rvalid_d;
  logic                  s_err_q, s_err_d, v_err_q, v_err_d;
  logic [DATA_WIDTH-1:0] s_rdata_q, s_rdata_d, v_rdata_q, v_rdata_d;

  sdmem_req_check #(.DATA_WIDTH(DATA_WIDTH), .MEM_SIZE(MEM_SIZE)) u_s_check (
    .size_i(s_size_i), .addr_i(s_addr_i), .ok_o(s_ok)
  );

  sdmem_req_check #(.DATA_WIDTH(DATA_WIDTH), .MEM_SIZE(MEM_SIZE)) u_v_check (
    .size_i(v_size_i), .addr_i(v_addr_i), .ok_o(v_ok)
  );

  // Pick this cycle's owner and advance the lock state and burst beat count.
  always_comb begin
    owner      = OWN_NONE;
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_v_d   = last_v_q;
    case (state_q)
      IDLE: begin
        if (s_req_i && v_req_i) owner = last_v_q ? OWN_S : OWN_V;
        else if (s_req_i)       owner = OWN_S;
        else if (v_req_i)       owner = OWN_V;
        if (owner == OWN_V && !v_last_i) begin
          state_d    = LOCK_V;
          beat_cnt_d = 8'd1;
        end
      end
      LOCK_V: begin
        if (s_req_i && beat_cnt_q == MAX_BEATS) begin
          owner      = OWN_S;
          beat_cnt_d = 8'd0;
        end else if (v_req_i) begin
          owner = OWN_V;
          if (v_last_i) begin
            state_d    = IDLE;
            beat_cnt_d = 8'd0;
          end else if (beat_cnt_q < MAX_BEATS) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end else if (s_req_i) begin
          owner = OWN_S;
        end
      end
      default: state_d = IDLE;
    endcase
    if (owner == OWN_S)      last_v_d = 1'b0;
    else if (owner == OWN_V) last_v_d = 1'b1;
  end

  assign s_gnt_o = (owner == OWN_S);
  assign v_gnt_o = (owner == OWN_V);

  // Route the granted requester to sdatamem; screened-out requests get no strobe.
  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_size_o  = 2'b00;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (owner)
      OWN_S: begin
        mem_read_o  = ~s_we_i & s_ok;
        mem_write_o = s_we_i & s_ok;
        mem_size_o  = s_size_i;
        mem_addr_o  = s_addr_i;
        mem_wdata_o = s_wdata_i;
      end
      OWN_V: begin
        mem_read_o  = ~v_we_i & v_ok;
        mem_write_o = v_we_i & v_ok;
        mem_size_o  = v_size_i;
        mem_addr_o  = v_addr_i;
        mem_wdata_o = v_wdata_i;
      end
      default: ;
    endcase
  end

  // Next response values; rdata and err only move when that side is granted.
  always_comb begin
    s_rvalid_d = s_gnt_o;
    v_rvalid_d = v_gnt_o;
    s_err_d    = s_gnt_o ? ~s_ok : s_err_q;
    v_err_d    = v_gnt_o ? ~v_ok : v_err_q;
    s_rdata_d  = s_rdata_q;
    v_rdata_d  = v_rdata_q;
    if (s_gnt_o) s_rdata_d = (s_ok && !s_we_i) ? mem_rdata_i : '0;
    if (v_gnt_o) v_rdata_d = (v_ok && !v_we_i) ? mem_rdata_i : '0;
  end

  // Arbitration state and response registers; reset drops any pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= 8'd0;
      last_v_q   <= 1'b1;
      s_rvalid_q <= 1'b0;
      v_rvalid_q <= 1'b0;
      s_err_q    <= 1'b0;
      v_err_q    <= 1'b0;
      s_rdata_q  <= '0;
      v_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_v_q   <= last_v_d;
      s_rvalid_q <= s_rvalid_d;
      v_rvalid_q <= v_rvalid_d;
      s_err_q    <= s_err_d;
      v_err_q    <= v_err_d;
      s_rdata_q  <= s_rdata_d;
      v_rdata_q  <= v_rdata_d;
    end
  end

  assign s_rvalid_o = s_rvalid_q;
  assign v_rvalid_o = v_rvalid_q;
  assign s_err_o    = s_err_q;
  assign v_err_o    = v_err_q;
  assign s_rdata_o  = s_rdata_q;
  assign v_rdata_o  = v_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_s_gnt_q, perf_s_gnt_d;
  logic [31:0] perf_v_gnt_q, perf_v_gnt_d;
  logic [31:0] perf_s_stall_q, perf_s_stall_d;

  // Saturating grant and scalar-stall counters.
  always_comb begin
    perf_s_gnt_d   = perf_s_gnt_q;
    perf_v_gnt_d   = perf_v_gnt_q;
    perf_s_stall_d = perf_s_stall_q;
    if (s_gnt_o && perf_s_gnt_q != 32'hFFFF_FFFF) perf_s_gnt_d = perf_s_gnt_q + 32'd1;
    if (v_gnt_o && perf_v_gnt_q != 32'hFFFF_FFFF) perf_v_gnt_d = perf_v_gnt_q + 32'd1;
    if (s_req_i && !s_gnt_o && perf_s_stall_q != 32'hFFFF_FFFF)
      perf_s_stall_d = perf_s_stall_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_s_gnt_q   <= 32'd0;
      perf_v_gnt_q   <= 32'd0;
      perf_s_stall_q <= 32'd0;
    end else begin
      perf_s_gnt_q   <= perf_s_gnt_d;
      perf_v_gnt_q   <= perf_v_gnt_d;
      perf_s_stall_q <= perf_s_stall_d;
    end
  end

  assign perf_s_gnt_o   = perf_s_gnt_q;
  assign perf_v_gnt_o   = perf_v_gnt_q;
  assign perf_s_stall_o = perf_s_stall_q;
`else
  assign perf_s_gnt_o   = 32'd0;
  assign perf_v_gnt_o   = 32'd0;
  assign perf_s_stall_o = 32'd0;
`endif

endmodule
